// File: rtl/data_mem_if.sv
// Load/store port between the core (master) and the data memory responder (slave).
// Request and response channels each use a valid/ready handshake.
interface data_mem_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: word-organised RAM behind valid/ready request and
// response channels, with WAIT_CYCLES extra cycles between accept and response.
// Optional build macro MISALIGN_TRAP_EN: when defined, a request whose byte
// address has nonzero bits [1:0] faults instead of accessing the containing word.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_if.slave   bus,
    output logic        busy
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request fields captured on the accept edge; fault is resolved up front.
    typedef struct packed {
        logic              we;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              fault;
    } req_t;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    req_t              req_q,       req_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              busy_q,      busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              mem_we_c;
    logic              range_fault_c;
    logic              align_fault_c;

    // Address decode of the incoming request: out-of-range and (optionally) misaligned.
    assign range_fault_c = |bus.req_addr[31:IDX_W+2];

`ifdef MISALIGN_TRAP_EN
    assign align_fault_c = |bus.req_addr[1:0];
`else
    logic unused_addr_lsb_c;
    assign align_fault_c     = 1'b0;
    assign unused_addr_lsb_c = ^bus.req_addr[1:0];
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic; commit happens on the last WAIT edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_d.we    = bus.req_we;
                    req_d.idx   = bus.req_addr[IDX_W+1:2];
                    req_d.wdata = bus.req_wdata;
                    req_d.be    = bus.req_be;
                    req_d.fault = range_fault_c | align_fault_c;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we_c    = req_q.we && !req_q.fault;
                    rsp_rdata_d = (!req_q.we && !req_q.fault) ? mem_q[req_q.idx] : '0;
                    rsp_err_d   = req_q.fault;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                req_ready_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Byte-enabled RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (req_q.be[b]) begin
                    mem_q[req_q.idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;

endmodule
